// File: rtl/aha_clk_gate_pkg.sv
// Shared definitions for the automatic clock-gating controller:
// the per-channel state encoding and default widths.
package aha_clk_gate_pkg;

  localparam int DEFAULT_NUM_CH = 4;
  localparam int DEFAULT_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_IDLE_CNT = 2'b01,
    ST_OFF      = 2'b10,
    ST_WAKE     = 2'b11
  } chan_state_e;

endpackage

// File: rtl/AhaClockGate.sv
// Latch-based integrated clock gate: the enable is captured while CP is low,
// so the gated clock never produces a shortened pulse.
module AhaClockGate (
  input  logic CP,
  input  logic E,
  input  logic TE,
  output logic Q
);

  logic en_latch;

  always_latch begin
    if (!CP) en_latch = E | TE;
  end

  assign Q = CP & en_latch;

endmodule

// File: rtl/aha_clock_gate_chan.sv
// One gated clock channel: idle hold-off FSM, registered enable/ready status
// and the ICG cell that produces the channel clock.
module aha_clock_gate_chan
  import aha_clk_gate_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             te,
  input  logic             keep,
  input  logic [CNT_W-1:0] hold_cycles,
  output logic             clk_en,
  output logic             ready,
  output logic             gclk
);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_en_q, clk_en_d;
  logic             ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (!keep) begin
          if (hold_cycles == '0) begin
            state_d = ST_OFF;
          end else begin
            state_d = ST_IDLE_CNT;
            cnt_d   = hold_cycles - CNT_W'(1);
          end
        end
      end
      // A keep request cancels the countdown even on its final cycle.
      ST_IDLE_CNT: begin
        if (keep) begin
          state_d = ST_RUN;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_OFF: begin
        if (keep) state_d = ST_WAKE;
      end
      ST_WAKE: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    clk_en_d = (state_d != ST_OFF);
    ready_d  = (state_d == ST_RUN) || (state_d == ST_IDLE_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      clk_en_q <= 1'b1;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      clk_en_q <= clk_en_d;
      ready_q  <= ready_d;
    end
  end

  assign clk_en = clk_en_q;
  assign ready  = ready_q;

  AhaClockGate u_icg (
    .CP (clk),
    .E  (clk_en_q),
    .TE (te),
    .Q  (gclk)
  );

endmodule

// File: rtl/aha_clock_gate_ctrl.sv
// Multi-channel automatic clock-gating controller: derives each channel's keep
// request, instantiates the channels and registers the all-channels-off flag.
module aha_clock_gate_ctrl
  import aha_clk_gate_pkg::*;
#(
  parameter int NUM_CH = DEFAULT_NUM_CH,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              TE,
  input  logic              GATE_EN,
  input  logic [CNT_W-1:0]  HOLD_CYCLES,
  input  logic [NUM_CH-1:0] ACTIVE,
  input  logic [NUM_CH-1:0] FORCE_ON,
  output logic [NUM_CH-1:0] GCLK,
  output logic [NUM_CH-1:0] CLK_EN,
  output logic [NUM_CH-1:0] READY,
  output logic              ALL_OFF
);

  logic [NUM_CH-1:0] keep;
  logic              all_off_q, all_off_d;

  assign keep = ACTIVE | FORCE_ON | {NUM_CH{~GATE_EN}};

  for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
    aha_clock_gate_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk         (CLK),
      .rst_n       (RESETn),
      .te          (TE),
      .keep        (keep[i]),
      .hold_cycles (HOLD_CYCLES),
      .clk_en      (CLK_EN[i]),
      .ready       (READY[i]),
      .gclk        (GCLK[i])
    );
  end

  // A channel's enable is low exactly when it sits in OFF.
  always_comb begin
    all_off_d = ~|CLK_EN;
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) all_off_q <= 1'b0;
    else         all_off_q <= all_off_d;
  end

  assign ALL_OFF = all_off_q;

endmodule

// File: tb/tb_aha_clock_gate_ctrl.sv
// Bench for aha_clock_gate_ctrl: directed stimulus, hand-computed spot checks
// and a per-cycle comparison against an idle-run-length model.
module tb_aha_clock_gate_ctrl;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic              CLK = 1'b0;
  logic              RESETn = 1'b0;
  logic              TE = 1'b0;
  logic              GATE_EN = 1'b1;
  logic [CNT_W-1:0]  HOLD_CYCLES = '0;
  logic [NUM_CH-1:0] ACTIVE = '1;
  logic [NUM_CH-1:0] FORCE_ON = '0;
  logic [NUM_CH-1:0] GCLK, CLK_EN, READY;
  logic              ALL_OFF;

  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  logic [NUM_CH-1:0] m_gated, m_waking;
  int                m_idle [NUM_CH];
  int                m_snap [NUM_CH];
  logic              m_all_off;

  aha_clock_gate_ctrl #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .CLK         (CLK),
    .RESETn      (RESETn),
    .TE          (TE),
    .GATE_EN     (GATE_EN),
    .HOLD_CYCLES (HOLD_CYCLES),
    .ACTIVE      (ACTIVE),
    .FORCE_ON    (FORCE_ON),
    .GCLK        (GCLK),
    .CLK_EN      (CLK_EN),
    .READY       (READY),
    .ALL_OFF     (ALL_OFF)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_gated   = '0;
    m_waking  = '0;
    m_all_off = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_idle[i] = 0;
      m_snap[i] = 0;
    end
  endtask

  // A channel gates once its run of idle edges exceeds the hold value captured
  // on the first idle edge; a keep request while gated costs one wake cycle.
  task automatic model_step();
    logic [NUM_CH-1:0] keep;
    keep = ACTIVE | FORCE_ON | {NUM_CH{~GATE_EN}};
    m_all_off = (m_gated == '1);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_waking[i]) begin
        m_waking[i] = 1'b0;
      end else if (m_gated[i]) begin
        if (keep[i]) begin
          m_gated[i]  = 1'b0;
          m_waking[i] = 1'b1;
        end
      end else if (keep[i]) begin
        m_idle[i] = 0;
      end else begin
        if (m_idle[i] == 0) m_snap[i] = int'(HOLD_CYCLES);
        m_idle[i]++;
        if (m_idle[i] == m_snap[i] + 1) begin
          m_gated[i] = 1'b1;
          m_idle[i]  = 0;
        end
      end
    end
  endtask

  always begin
    logic [NUM_CH-1:0] prev_en, exp_en, exp_rdy, exp_gclk;
    logic              te_s;
    @(posedge CLK or negedge RESETn);
    if (!RESETn) begin
      model_reset();
    end else begin
      prev_en = ~m_gated;
      te_s    = TE;
      model_step();
      #1;
      if (check_en) begin
        exp_en   = ~m_gated;
        exp_rdy  = ~m_gated & ~m_waking;
        exp_gclk = prev_en | {NUM_CH{te_s}};
        check_output("model_clk_en", 32'(CLK_EN), 32'(exp_en));
        check_output("model_ready", 32'(READY), 32'(exp_rdy));
        check_output("model_all_off", 32'(ALL_OFF), 32'(m_all_off));
        check_output("model_gclk_high", 32'(GCLK), 32'(exp_gclk));
      end
    end
  end

  task automatic apply_stimulus(input logic [NUM_CH-1:0] act, input logic [NUM_CH-1:0] frc,
                                input logic gen, input logic [CNT_W-1:0] hold);
    ACTIVE      = act;
    FORCE_ON    = frc;
    GATE_EN     = gen;
    HOLD_CYCLES = hold;
  endtask

  task automatic check_gclk_high(input string name, input logic [NUM_CH-1:0] exp);
    @(posedge CLK);
    #2;
    check_output(name, 32'(GCLK), 32'(exp));
  endtask

  initial begin
    // Reset with arbitrary inputs
    RESETn = 1'b0;
    ACTIVE = NUM_CH'($urandom);
    FORCE_ON = NUM_CH'($urandom);
    GATE_EN = 1'($urandom);
    HOLD_CYCLES = CNT_W'($urandom);
    TE = 1'($urandom);
    repeat (3) @(negedge CLK);
    check_output("reset_clk_en", 32'(CLK_EN), 32'h0000_000F);
    check_output("reset_ready", 32'(READY), 32'h0000_000F);
    check_output("reset_all_off", 32'(ALL_OFF), 32'h0);
    TE = 1'b0;
    apply_stimulus(4'hF, 4'h0, 1'b1, 8'd3);
    RESETn   = 1'b1;
    check_en = 1'b1;
    check_gclk_high("reset_gclk_high", 4'hF);
    @(negedge CLK);
    #1;
    check_output("reset_gclk_low", 32'(GCLK), 32'h0);
    repeat (2) @(negedge CLK);

    // Idle countdown on channel 0 with HOLD_CYCLES=3
    apply_stimulus(4'hE, 4'h0, 1'b1, 8'd3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      check_output("idle_clk_en", 32'(CLK_EN), (k < 4) ? 32'h0000_000F : 32'h0000_000E);
    end
    check_output("idle_ready", 32'(READY), 32'h0000_000E);
    check_gclk_high("idle_gclk", 4'hE);
    @(negedge CLK);

    // Zero hold on channel 1, then wake
    apply_stimulus(4'hC, 4'h0, 1'b1, 8'd0);
    @(negedge CLK);
    check_output("zero_clk_en", 32'(CLK_EN), 32'h0000_000C);
    check_output("zero_ready", 32'(READY), 32'h0000_000C);
    apply_stimulus(4'hE, 4'h0, 1'b1, 8'd0);
    @(negedge CLK);
    check_output("wake_clk_en", 32'(CLK_EN), 32'h0000_000E);
    check_output("wake_ready_n", 32'(READY), 32'h0000_000C);
    @(negedge CLK);
    check_output("wake_ready_n1", 32'(READY), 32'h0000_000E);

    // Channel 2 countdown cancelled on its final cycle; hold change mid-count ignored
    apply_stimulus(4'hA, 4'h0, 1'b1, 8'd5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      check_output("cancel_clk_en", 32'(CLK_EN), 32'h0000_000E);
      if (k == 2) HOLD_CYCLES = 8'd1;
    end
    apply_stimulus(4'hE, 4'h0, 1'b1, 8'd1);
    @(negedge CLK);
    check_output("cancel_clk_en_end", 32'(CLK_EN), 32'h0000_000E);
    check_output("cancel_ready_end", 32'(READY), 32'h0000_000E);

    // FORCE_ON keeps channel 3, then GATE_EN=0 wakes everything
    apply_stimulus(4'h0, 4'h8, 1'b1, 8'd1);
    repeat (150) @(negedge CLK);
    check_output("force_clk_en", 32'(CLK_EN), 32'h0000_0008);
    check_output("force_ready", 32'(READY), 32'h0000_0008);
    check_output("force_all_off", 32'(ALL_OFF), 32'h0);
    GATE_EN = 1'b0;
    @(negedge CLK);
    check_output("gate_dis_clk_en", 32'(CLK_EN), 32'h0000_000F);
    check_output("gate_dis_ready_n", 32'(READY), 32'h0000_0008);
    @(negedge CLK);
    check_output("gate_dis_ready_n1", 32'(READY), 32'h0000_000F);
    repeat (150) @(negedge CLK);
    check_output("gate_dis_hold", 32'(CLK_EN), 32'h0000_000F);

    // All channels idle, channel 3 last; ALL_OFF lags by one cycle
    apply_stimulus(4'h0, 4'h8, 1'b1, 8'd2);
    repeat (3) @(negedge CLK);
    check_output("stagger_clk_en", 32'(CLK_EN), 32'h0000_0008);
    check_output("stagger_all_off", 32'(ALL_OFF), 32'h0);
    FORCE_ON = 4'h0;
    repeat (3) @(negedge CLK);
    check_output("alloff_clk_en", 32'(CLK_EN), 32'h0);
    check_output("alloff_lag", 32'(ALL_OFF), 32'h0);
    @(negedge CLK);
    check_output("alloff_set", 32'(ALL_OFF), 32'h1);

    // Scan enable while all channels are off
    TE = 1'b1;
    check_gclk_high("te_gclk", 4'hF);
    check_output("te_clk_en", 32'(CLK_EN), 32'h0);
    check_output("te_ready", 32'(READY), 32'h0);
    check_output("te_all_off", 32'(ALL_OFF), 32'h1);
    @(negedge CLK);
    TE = 1'b0;
    check_gclk_high("te_off_gclk", 4'h0);
    check_output("te_off_all_off", 32'(ALL_OFF), 32'h1);

    // Asynchronous reset while off
    RESETn = 1'b0;
    #1;
    check_output("async_rst_clk_en", 32'(CLK_EN), 32'h0000_000F);
    check_output("async_rst_ready", 32'(READY), 32'h0000_000F);
    check_output("async_rst_all_off", 32'(ALL_OFF), 32'h0);
    repeat (2) @(negedge CLK);
    apply_stimulus(4'hF, 4'h0, 1'b1, 8'd2);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    check_output("post_rst_clk_en", 32'(CLK_EN), 32'h0000_000F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
